axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin between masters; 1 = master 0 always wins.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 m0_/m1_ AWdata, ARdata, Wdata  in  32 each  write address, read address, write data from master n.
REQ-005 m0_/m1_ AWvalid, ARvalid, Wvalid, Rready, Bready  in  1 each  master handshake inputs.
REQ-006 m0_/m1_ AWprot, ARprot  in  3 each; m0_/m1_Wstrb  in  4  master protection and strobes.
REQ-007 m0_/m1_ AWready, ARready, Wready, Rvalid, Bvalid  out  1 each; m0_/m1_Rdata  out  32  responses to master n.
REQ-008 s_AWdata, s_ARdata, s_Wdata  out  32; s_AWprot, s_ARprot  out  3; s_Wstrb  out  4  to the shared slave.
REQ-009 s_AWvalid, s_ARvalid, s_Wvalid, s_Rready, s_Bready  out  1 each  to the shared slave.
REQ-010 s_AWready, s_ARready, s_Wready, s_Rvalid, s_Bvalid  in  1 each; s_Rdata  in  32  from the shared slave.
REQ-011 grant  out  2  one-hot owner (bit n = master n), 2'b00 when idle; busy  out  1  high in RD or WR.

Function
REQ-012 The FSM SHALL have three states: IDLE, RD, WR.
REQ-013 A master SHALL request a write when AWvalid or Wvalid is high, and a read when ARvalid is high.
REQ-014 In IDLE with any request, the winner SHALL be selected and state SHALL move to WR (winner requests write) or RD (read only) on the next edge; write wins within one master.
REQ-015 Round-robin: with both masters requesting, the master not granted last SHALL win; the last-grant pointer SHALL update only on entry to RD/WR.
REQ-016 With FIXED_PRIO=1, master 0 SHALL win every contention.
REQ-017 In RD/WR, the granted master's address, data, prot, strobe, valid and ready signals SHALL be routed combinationally to the s_ ports and the slave's responses back to that master.
REQ-018 The non-granted master SHALL see all its ready/valid outputs at 0 and Rdata at 0.
REQ-019 In IDLE, all s_ valid/ready outputs and all master ready/valid outputs SHALL be 0; s_ data/address outputs SHALL be 0.
REQ-020 RD SHALL end on the cycle s_Rvalid and s_Rready are both high; WR SHALL end on the cycle s_Bvalid and s_Bready are both high; state SHALL return to IDLE on the next edge.
REQ-021 Grant SHALL NOT change mid-transaction, even if the owner deasserts valid or the other master requests.
REQ-022 Minimum arbitration overhead SHALL be 1 IDLE cycle between transactions; a request present in IDLE is granted 1 cycle later.
REQ-023 AW and W handshakes inside WR SHALL pass through independently (either order), with no buffering in the arbiter.
REQ-024 A request withdrawn before grant SHALL be dropped without entering RD/WR.

Reset
REQ-025 On rstn low, state SHALL go to IDLE asynchronously, grant=2'b00, busy=0, last-grant pointer=master 1 (so master 0 wins first contention), and all outputs SHALL take REQ-019 values.
REQ-026 Reset asserted mid-transaction SHALL abort it; no response SHALL be forwarded afterwards.

Verification
REQ-027 m0 ARvalid, ARdata=0x100; slave ARready next cycle, Rvalid with Rdata=0xDEADBEEF -> grant=01 one cycle after request, m0_Rdata=0xDEADBEEF, m1 outputs 0, IDLE after R handshake.
REQ-028 m0 and m1 both request reads simultaneously out of reset, held continuously -> grants alternate 01,10,01,10 over four transactions (FIXED_PRIO=0).
REQ-029 Same as REQ-028 with FIXED_PRIO=1 -> grant=01 on all four transactions; m1 never granted while m0 requests.
REQ-030 m1 write, AWdata=0x200, Wdata=0x12345678, Wstrb=4'hF; slave gives Wready before AWready, Bvalid 3 cycles later -> s_ ports mirror m1 values; WR held until B handshake; m0 ARvalid asserted meanwhile stays unserved until IDLE.
REQ-031 m0 asserts ARvalid and AWvalid together -> WR entered first, RD follows after 1 IDLE cycle.
REQ-032 rstn pulsed low during RD while slave Rvalid is pending -> grant=00, busy=0 immediately; m0_Rvalid stays 0.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter: one whole transaction (read or write)
// owns the slave at a time; round-robin or fixed master-0 priority.
module axi_lite_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m0_AWdata,
  input  logic [31:0] m0_ARdata,
  input  logic [31:0] m0_Wdata,
  input  logic        m0_AWvalid,
  input  logic        m0_ARvalid,
  input  logic        m0_Wvalid,
  input  logic        m0_Rready,
  input  logic        m0_Bready,
  input  logic [2:0]  m0_AWprot,
  input  logic [2:0]  m0_ARprot,
  input  logic [3:0]  m0_Wstrb,
  output logic        m0_AWready,
  output logic        m0_ARready,
  output logic        m0_Wready,
  output logic        m0_Rvalid,
  output logic        m0_Bvalid,
  output logic [31:0] m0_Rdata,
  input  logic [31:0] m1_AWdata,
  input  logic [31:0] m1_ARdata,
  input  logic [31:0] m1_Wdata,
  input  logic        m1_AWvalid,
  input  logic        m1_ARvalid,
  input  logic        m1_Wvalid,
  input  logic        m1_Rready,
  input  logic        m1_Bready,
  input  logic [2:0]  m1_AWprot,
  input  logic [2:0]  m1_ARprot,
  input  logic [3:0]  m1_Wstrb,
  output logic        m1_AWready,
  output logic        m1_ARready,
  output logic        m1_Wready,
  output logic        m1_Rvalid,
  output logic        m1_Bvalid,
  output logic [31:0] m1_Rdata,
  output logic [31:0] s_AWdata,
  output logic [31:0] s_ARdata,
  output logic [31:0] s_Wdata,
  output logic [2:0]  s_AWprot,
  output logic [2:0]  s_ARprot,
  output logic [3:0]  s_Wstrb,
  output logic        s_AWvalid,
  output logic        s_ARvalid,
  output logic        s_Wvalid,
  output logic        s_Rready,
  output logic        s_Bready,
  input  logic        s_AWready,
  input  logic        s_ARready,
  input  logic        s_Wready,
  input  logic        s_Rvalid,
  input  logic        s_Bvalid,
  input  logic [31:0] s_Rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  typedef struct packed {
    logic [31:0] awdata;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic [31:0] ardata;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
    logic        bready;
  } mreq_t;

  mreq_t [1:0] mreq;
  mreq_t       own;
  state_t      state_q;
  logic [1:0]  grant_q;
  logic        busy_q;
  logic        last_q;
  logic [1:0]  wr_req, any_req;
  logic        win, rd_act, wr_act;
  logic [1:0]  awrdy, arrdy, wrdy, rvld, bvld;
  logic [1:0][31:0] rdata;

  assign mreq[0] = '{awdata: m0_AWdata, awprot: m0_AWprot, awvalid: m0_AWvalid,
                     wdata: m0_Wdata, wstrb: m0_Wstrb, wvalid: m0_Wvalid,
                     ardata: m0_ARdata, arprot: m0_ARprot, arvalid: m0_ARvalid,
                     rready: m0_Rready, bready: m0_Bready};
  assign mreq[1] = '{awdata: m1_AWdata, awprot: m1_AWprot, awvalid: m1_AWvalid,
                     wdata: m1_Wdata, wstrb: m1_Wstrb, wvalid: m1_Wvalid,
                     ardata: m1_ARdata, arprot: m1_ARprot, arvalid: m1_ARvalid,
                     rready: m1_Rready, bready: m1_Bready};

  assign wr_req  = {m1_AWvalid | m1_Wvalid, m0_AWvalid | m0_Wvalid};
  assign any_req = wr_req | {m1_ARvalid, m0_ARvalid};

  // last_q holds the index of the master granted most recently
  always_comb begin
    win = 1'b0;
    if (&any_req) win = FIXED_PRIO ? 1'b0 : ~last_q;
    else          win = any_req[1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (|any_req) begin
          state_q <= wr_req[win] ? WR : RD;
          grant_q <= win ? 2'b10 : 2'b01;
          busy_q  <= 1'b1;
          last_q  <= win;
        end
        RD: if (s_Rvalid && s_Rready) begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        WR: if (s_Bvalid && s_Bready) begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign busy   = busy_q;
  assign rd_act = (state_q == RD);
  assign wr_act = (state_q == WR);
  assign own    = mreq[grant_q[1]];

  // Channels are opened per transaction type so a pending request of the other
  // type from the owner cannot slip through to the slave.
  assign s_ARdata  = rd_act ? own.ardata : '0;
  assign s_ARprot  = rd_act ? own.arprot : '0;
  assign s_ARvalid = rd_act & own.arvalid;
  assign s_Rready  = rd_act & own.rready;
  assign s_AWdata  = wr_act ? own.awdata : '0;
  assign s_AWprot  = wr_act ? own.awprot : '0;
  assign s_Wdata   = wr_act ? own.wdata  : '0;
  assign s_Wstrb   = wr_act ? own.wstrb  : '0;
  assign s_AWvalid = wr_act & own.awvalid;
  assign s_Wvalid  = wr_act & own.wvalid;
  assign s_Bready  = wr_act & own.bready;

  for (genvar n = 0; n < 2; n++) begin : g_rsp
    assign arrdy[n] = grant_q[n] & rd_act & s_ARready;
    assign rvld[n]  = grant_q[n] & rd_act & s_Rvalid;
    assign rdata[n] = (grant_q[n] & rd_act) ? s_Rdata : '0;
    assign awrdy[n] = grant_q[n] & wr_act & s_AWready;
    assign wrdy[n]  = grant_q[n] & wr_act & s_Wready;
    assign bvld[n]  = grant_q[n] & wr_act & s_Bvalid;
  end

  assign {m1_AWready, m0_AWready} = awrdy;
  assign {m1_ARready, m0_ARready} = arrdy;
  assign {m1_Wready,  m0_Wready}  = wrdy;
  assign {m1_Rvalid,  m0_Rvalid}  = rvld;
  assign {m1_Bvalid,  m0_Bvalid}  = bvld;
  assign m0_Rdata = rdata[0];
  assign m1_Rdata = rdata[1];

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: masters and a behavioural slave are
// driven from tasks; a monitor pops expected grants/responses as they appear.
module tb_axi_lite_arbiter;

  typedef struct packed {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } rsp_t;

  logic clk = 1'b0, rstn;
  always #5 clk = ~clk;

  logic [31:0] m0_AWdata, m0_ARdata, m0_Wdata, m1_AWdata, m1_ARdata, m1_Wdata;
  logic        m0_AWvalid, m0_ARvalid, m0_Wvalid, m0_Rready, m0_Bready;
  logic        m1_AWvalid, m1_ARvalid, m1_Wvalid, m1_Rready, m1_Bready;
  logic [2:0]  m0_AWprot, m0_ARprot, m1_AWprot, m1_ARprot;
  logic [3:0]  m0_Wstrb, m1_Wstrb;
  logic        m0_AWready, m0_ARready, m0_Wready, m0_Rvalid, m0_Bvalid;
  logic        m1_AWready, m1_ARready, m1_Wready, m1_Rvalid, m1_Bvalid;
  logic [31:0] m0_Rdata, m1_Rdata;
  logic [31:0] s_AWdata, s_ARdata, s_Wdata, s_Rdata;
  logic [2:0]  s_AWprot, s_ARprot;
  logic [3:0]  s_Wstrb;
  logic        s_AWvalid, s_ARvalid, s_Wvalid, s_Rready, s_Bready;
  logic        s_AWready, s_ARready, s_Wready, s_Rvalid, s_Bvalid;
  logic [1:0]  grant;
  logic        busy;

  axi_lite_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rstn(rstn),
    .m0_AWdata(m0_AWdata), .m0_ARdata(m0_ARdata), .m0_Wdata(m0_Wdata),
    .m0_AWvalid(m0_AWvalid), .m0_ARvalid(m0_ARvalid), .m0_Wvalid(m0_Wvalid),
    .m0_Rready(m0_Rready), .m0_Bready(m0_Bready),
    .m0_AWprot(m0_AWprot), .m0_ARprot(m0_ARprot), .m0_Wstrb(m0_Wstrb),
    .m0_AWready(m0_AWready), .m0_ARready(m0_ARready), .m0_Wready(m0_Wready),
    .m0_Rvalid(m0_Rvalid), .m0_Bvalid(m0_Bvalid), .m0_Rdata(m0_Rdata),
    .m1_AWdata(m1_AWdata), .m1_ARdata(m1_ARdata), .m1_Wdata(m1_Wdata),
    .m1_AWvalid(m1_AWvalid), .m1_ARvalid(m1_ARvalid), .m1_Wvalid(m1_Wvalid),
    .m1_Rready(m1_Rready), .m1_Bready(m1_Bready),
    .m1_AWprot(m1_AWprot), .m1_ARprot(m1_ARprot), .m1_Wstrb(m1_Wstrb),
    .m1_AWready(m1_AWready), .m1_ARready(m1_ARready), .m1_Wready(m1_Wready),
    .m1_Rvalid(m1_Rvalid), .m1_Bvalid(m1_Bvalid), .m1_Rdata(m1_Rdata),
    .s_AWdata(s_AWdata), .s_ARdata(s_ARdata), .s_Wdata(s_Wdata),
    .s_AWprot(s_AWprot), .s_ARprot(s_ARprot), .s_Wstrb(s_Wstrb),
    .s_AWvalid(s_AWvalid), .s_ARvalid(s_ARvalid), .s_Wvalid(s_Wvalid),
    .s_Rready(s_Rready), .s_Bready(s_Bready),
    .s_AWready(s_AWready), .s_ARready(s_ARready), .s_Wready(s_Wready),
    .s_Rvalid(s_Rvalid), .s_Bvalid(s_Bvalid), .s_Rdata(s_Rdata),
    .grant(grant), .busy(busy)
  );

  // Fixed-priority instance: both masters read continuously against an always-ready slave
  logic        one, zb, fp_arv;
  logic [31:0] z32;
  logic [2:0]  z3;
  logic [3:0]  z4;
  logic        fp_m0_AWready, fp_m0_ARready, fp_m0_Wready, fp_m0_Rvalid, fp_m0_Bvalid;
  logic        fp_m1_AWready, fp_m1_ARready, fp_m1_Wready, fp_m1_Rvalid, fp_m1_Bvalid;
  logic [31:0] fp_m0_Rdata, fp_m1_Rdata, fp_s_AWdata, fp_s_ARdata, fp_s_Wdata;
  logic [2:0]  fp_s_AWprot, fp_s_ARprot;
  logic [3:0]  fp_s_Wstrb;
  logic        fp_s_AWvalid, fp_s_ARvalid, fp_s_Wvalid, fp_s_Rready, fp_s_Bready;
  logic [1:0]  fp_grant;
  logic        fp_busy;

  axi_lite_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rstn(rstn),
    .m0_AWdata(z32), .m0_ARdata(z32), .m0_Wdata(z32),
    .m0_AWvalid(zb), .m0_ARvalid(fp_arv), .m0_Wvalid(zb),
    .m0_Rready(one), .m0_Bready(one),
    .m0_AWprot(z3), .m0_ARprot(z3), .m0_Wstrb(z4),
    .m0_AWready(fp_m0_AWready), .m0_ARready(fp_m0_ARready), .m0_Wready(fp_m0_Wready),
    .m0_Rvalid(fp_m0_Rvalid), .m0_Bvalid(fp_m0_Bvalid), .m0_Rdata(fp_m0_Rdata),
    .m1_AWdata(z32), .m1_ARdata(z32), .m1_Wdata(z32),
    .m1_AWvalid(zb), .m1_ARvalid(fp_arv), .m1_Wvalid(zb),
    .m1_Rready(one), .m1_Bready(one),
    .m1_AWprot(z3), .m1_ARprot(z3), .m1_Wstrb(z4),
    .m1_AWready(fp_m1_AWready), .m1_ARready(fp_m1_ARready), .m1_Wready(fp_m1_Wready),
    .m1_Rvalid(fp_m1_Rvalid), .m1_Bvalid(fp_m1_Bvalid), .m1_Rdata(fp_m1_Rdata),
    .s_AWdata(fp_s_AWdata), .s_ARdata(fp_s_ARdata), .s_Wdata(fp_s_Wdata),
    .s_AWprot(fp_s_AWprot), .s_ARprot(fp_s_ARprot), .s_Wstrb(fp_s_Wstrb),
    .s_AWvalid(fp_s_AWvalid), .s_ARvalid(fp_s_ARvalid), .s_Wvalid(fp_s_Wvalid),
    .s_Rready(fp_s_Rready), .s_Bready(fp_s_Bready),
    .s_AWready(one), .s_ARready(one), .s_Wready(one),
    .s_Rvalid(one), .s_Bvalid(one), .s_Rdata(z32),
    .grant(fp_grant), .busy(fp_busy)
  );

  int   checks = 0, errors = 0, fp_cnt = 0;
  logic [1:0] exp_g[$];
  rsp_t exp_r[$];
  logic [31:0] slv_ar_addr, slv_aw_addr, slv_wdata;
  logic [2:0]  slv_arprot, slv_awprot;
  logic [3:0]  slv_wstrb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s act=timeout exp=event", nm);
  endtask

  // Behavioural slave: W accepted before AW, B three cycles after both, R one after AR
  initial begin
    bit w_done, aw_done;
    int bcnt;
    logic nar, nrv, naw, nw, nbv;
    logic [31:0] nrd;
    {s_ARready, s_Rvalid, s_AWready, s_Wready, s_Bvalid} = '0;
    s_Rdata = '0;
    w_done = 0; aw_done = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      nar = s_ARready; nrv = s_Rvalid; nrd = s_Rdata;
      naw = s_AWready; nw = s_Wready; nbv = s_Bvalid;
      if (s_ARvalid && s_ARready) begin
        slv_ar_addr = s_ARdata; slv_arprot = s_ARprot;
        nar = 0; nrv = 1;
        nrd = (s_ARdata == 32'h100) ? 32'hDEADBEEF : (s_ARdata ^ 32'hA5A50000);
      end else if (s_ARvalid && !s_Rvalid) nar = 1;
      if (s_Rvalid && s_Rready) nrv = 0;
      if (s_Wvalid && s_Wready) begin
        slv_wdata = s_Wdata; slv_wstrb = s_Wstrb; nw = 0; w_done = 1;
      end else if (s_Wvalid && !w_done) nw = 1;
      if (s_AWvalid && s_AWready) begin
        slv_aw_addr = s_AWdata; slv_awprot = s_AWprot; naw = 0; aw_done = 1;
      end else if (s_AWvalid && w_done && !aw_done) naw = 1;
      if (aw_done && w_done && !s_Bvalid) begin
        bcnt++;
        if (bcnt == 3) nbv = 1;
      end
      if (s_Bvalid && s_Bready) begin
        nbv = 0; aw_done = 0; w_done = 0; bcnt = 0;
      end
      @(posedge clk); #1;
      if (!rstn) begin
        {s_ARready, s_Rvalid, s_AWready, s_Wready, s_Bvalid} = '0;
        w_done = 0; aw_done = 0; bcnt = 0;
      end else begin
        s_ARready = nar; s_Rvalid = nrv; s_Rdata = nrd;
        s_AWready = naw; s_Wready = nw; s_Bvalid = nbv;
      end
    end
  end

  // Monitor for the round-robin instance
  initial begin
    bit busy_prev, chk_idle;
    rsp_t got;
    busy_prev = 0; chk_idle = 0;
    forever begin
      @(negedge clk);
      if (!rstn) chk_idle = 0;
      else begin
        if (chk_idle) begin
          chk("idle_after_rsp", 128'({busy, grant}), 128'(0));
          chk_idle = 0;
        end
        if (busy && !busy_prev) begin
          if (exp_g.size() == 0) tmo("grant_unexpected");
          else chk("grant", 128'(grant), 128'(exp_g.pop_front()));
        end
        if ((m0_Rvalid && m0_Rready) || (m1_Rvalid && m1_Rready)) begin
          got = '{m: m1_Rvalid, wr: 1'b0, addr: slv_ar_addr,
                  data: m1_Rvalid ? m1_Rdata : m0_Rdata, strb: 4'h0, prot: slv_arprot};
          if (exp_r.size() == 0) tmo("rd_rsp_unexpected");
          else chk("rd_rsp", 128'(got), 128'(exp_r.pop_front()));
          chk("rd_other_quiet", m1_Rvalid ?
              128'({m0_AWready, m0_ARready, m0_Wready, m0_Rvalid, m0_Bvalid, m0_Rdata}) :
              128'({m1_AWready, m1_ARready, m1_Wready, m1_Rvalid, m1_Bvalid, m1_Rdata}), 128'(0));
          chk_idle = 1;
        end
        if ((m0_Bvalid && m0_Bready) || (m1_Bvalid && m1_Bready)) begin
          got = '{m: m1_Bvalid, wr: 1'b1, addr: slv_aw_addr,
                  data: slv_wdata, strb: slv_wstrb, prot: slv_awprot};
          if (exp_r.size() == 0) tmo("wr_rsp_unexpected");
          else chk("wr_rsp", 128'(got), 128'(exp_r.pop_front()));
          chk("wr_other_quiet", m1_Bvalid ?
              128'({m0_AWready, m0_ARready, m0_Wready, m0_Rvalid, m0_Bvalid, m0_Rdata}) :
              128'({m1_AWready, m1_ARready, m1_Wready, m1_Rvalid, m1_Bvalid, m1_Rdata}), 128'(0));
          chk_idle = 1;
        end
      end
      busy_prev = busy;
    end
  end

  // Monitor for the fixed-priority instance: first four grants must all go to m0
  initial begin
    bit fp_prev;
    fp_prev = 0;
    forever begin
      @(negedge clk);
      if (rstn && fp_busy && !fp_prev && fp_cnt < 4) begin
        chk("fp_grant", 128'(fp_grant), 128'(2'b01));
        fp_cnt++;
      end
      fp_prev = fp_busy;
    end
  end

  task automatic rd(input bit m, input logic [31:0] a);
    bit hs;
    if (m) begin m1_ARdata = a; m1_ARprot = 3'b001; m1_ARvalid = 1; end
    else   begin m0_ARdata = a; m0_ARprot = 3'b001; m0_ARvalid = 1; end
    hs = 0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = m ? (m1_ARvalid && m1_ARready) : (m0_ARvalid && m0_ARready);
    end
    if (!hs) tmo("rd_ar_wait");
    @(posedge clk); #1;
    if (m) m1_ARvalid = 0; else m0_ARvalid = 0;
    hs = 0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = m ? (m1_Rvalid && m1_Rready) : (m0_Rvalid && m0_Rready);
    end
    if (!hs) tmo("rd_r_wait");
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit m, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] st, input logic [2:0] pr);
    bit aw_hs, w_hs, aw_ok, w_ok, hs;
    if (m) begin
      m1_AWdata = a; m1_Wdata = d; m1_Wstrb = st; m1_AWprot = pr; m1_AWvalid = 1; m1_Wvalid = 1;
    end else begin
      m0_AWdata = a; m0_Wdata = d; m0_Wstrb = st; m0_AWprot = pr; m0_AWvalid = 1; m0_Wvalid = 1;
    end
    aw_ok = 0; w_ok = 0;
    for (int i = 0; i < 200 && !(aw_ok && w_ok); i++) begin
      @(negedge clk);
      aw_hs = m ? (m1_AWvalid && m1_AWready) : (m0_AWvalid && m0_AWready);
      w_hs  = m ? (m1_Wvalid && m1_Wready)   : (m0_Wvalid && m0_Wready);
      @(posedge clk); #1;
      if (aw_hs) begin aw_ok = 1; if (m) m1_AWvalid = 0; else m0_AWvalid = 0; end
      if (w_hs)  begin w_ok = 1;  if (m) m1_Wvalid = 0;  else m0_Wvalid = 0;  end
    end
    if (!(aw_ok && w_ok)) tmo("wr_aw_w_wait");
    hs = 0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = m ? (m1_Bvalid && m1_Bready) : (m0_Bvalid && m0_Bready);
    end
    if (!hs) tmo("wr_b_wait");
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    one = 1; zb = 0; z32 = '0; z3 = '0; z4 = '0; fp_arv = 0;
    {m0_AWdata, m0_ARdata, m0_Wdata, m1_AWdata, m1_ARdata, m1_Wdata} = '0;
    {m0_AWprot, m0_ARprot, m1_AWprot, m1_ARprot, m0_Wstrb, m1_Wstrb} = '0;
    {m0_AWvalid, m0_ARvalid, m0_Wvalid, m1_AWvalid, m1_ARvalid, m1_Wvalid} = '0;
    {m0_Rready, m0_Bready, m1_Rready, m1_Bready} = 4'hF;
    rstn = 0;
    // Requests present while held in reset must not leak through
    m0_ARvalid = 1; m0_ARdata = 32'h55; m1_AWvalid = 1; m1_Wvalid = 1;
    m1_AWdata = 32'h66; m1_Wdata = 32'h77; m1_Wstrb = 4'hF;
    repeat (3) @(posedge clk); #1;
    chk("rst_state", 128'({grant, busy}), 128'(0));
    chk("rst_s_outputs", 128'({s_AWvalid, s_ARvalid, s_Wvalid, s_Rready, s_Bready,
        s_AWdata, s_ARdata, s_Wdata, s_Wstrb, s_AWprot, s_ARprot}), 128'(0));
    chk("rst_m_outputs", 128'({m0_AWready, m0_ARready, m0_Wready, m0_Rvalid, m0_Bvalid,
        m1_AWready, m1_ARready, m1_Wready, m1_Rvalid, m1_Bvalid, m0_Rdata, m1_Rdata}), 128'(0));
    {m0_ARvalid, m1_AWvalid, m1_Wvalid} = '0;
    rstn = 1;
    @(posedge clk); #1;

    // Fixed priority: four back-to-back contentions
    fp_arv = 1;
    for (int i = 0; i < 40 && fp_cnt < 4; i++) @(posedge clk);
    #1 fp_arv = 0;
    chk("fp_count", 128'(fp_cnt), 128'(4));

    // Single m0 read, grant one cycle after the request
    exp_g.push_back(2'b01);
    exp_r.push_back('{m: 1'b0, wr: 1'b0, addr: 32'h100, data: 32'hDEADBEEF, strb: 4'h0, prot: 3'b001});
    fork
      rd(1'b0, 32'h100);
      begin
        @(negedge clk); chk("t1_grant_pre", 128'(grant), 128'(0));
        @(negedge clk); chk("t1_grant_post", 128'(grant), 128'(2'b01));
      end
    join
    repeat (2) @(posedge clk); #1;

    // Round-robin out of reset with both masters reading continuously
    do_reset();
    exp_g.push_back(2'b01); exp_g.push_back(2'b10); exp_g.push_back(2'b01); exp_g.push_back(2'b10);
    exp_r.push_back('{m: 1'b0, wr: 1'b0, addr: 32'h104, data: 32'hA5A50104, strb: 4'h0, prot: 3'b001});
    exp_r.push_back('{m: 1'b1, wr: 1'b0, addr: 32'h204, data: 32'hA5A50204, strb: 4'h0, prot: 3'b001});
    exp_r.push_back('{m: 1'b0, wr: 1'b0, addr: 32'h108, data: 32'hA5A50108, strb: 4'h0, prot: 3'b001});
    exp_r.push_back('{m: 1'b1, wr: 1'b0, addr: 32'h208, data: 32'hA5A50208, strb: 4'h0, prot: 3'b001});
    fork
      begin rd(1'b0, 32'h104); rd(1'b0, 32'h108); end
      begin rd(1'b1, 32'h204); rd(1'b1, 32'h208); end
    join
    repeat (2) @(posedge clk); #1;

    // m1 write held to B handshake while m0 read waits
    exp_g.push_back(2'b10); exp_g.push_back(2'b01);
    exp_r.push_back('{m: 1'b1, wr: 1'b1, addr: 32'h200, data: 32'h12345678, strb: 4'hF, prot: 3'b010});
    exp_r.push_back('{m: 1'b0, wr: 1'b0, addr: 32'h10C, data: 32'hA5A5010C, strb: 4'h0, prot: 3'b001});
    fork
      wr(1'b1, 32'h200, 32'h12345678, 4'hF, 3'b010);
      begin repeat (2) @(posedge clk); #1; rd(1'b0, 32'h10C); end
    join
    repeat (2) @(posedge clk); #1;

    // Same master asks for write and read together: write goes first
    exp_g.push_back(2'b01); exp_g.push_back(2'b01);
    exp_r.push_back('{m: 1'b0, wr: 1'b1, addr: 32'h300, data: 32'hCAFEF00D, strb: 4'h3, prot: 3'b000});
    exp_r.push_back('{m: 1'b0, wr: 1'b0, addr: 32'h110, data: 32'hA5A50110, strb: 4'h0, prot: 3'b001});
    fork
      wr(1'b0, 32'h300, 32'hCAFEF00D, 4'h3, 3'b000);
      rd(1'b0, 32'h110);
    join
    repeat (2) @(posedge clk); #1;

    // Reset during a read with R pending
    exp_g.push_back(2'b01);
    m0_Rready = 0; m0_ARdata = 32'h114; m0_ARprot = 3'b001; m0_ARvalid = 1;
    hs = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = m0_ARvalid && m0_ARready;
    end
    if (!hs) tmo("t5_ar_wait");
    @(posedge clk); #1 m0_ARvalid = 0;
    @(posedge clk); #1;
    chk("t5_r_pending", 128'({m0_Rvalid, busy}), 128'(2'b11));
    rstn = 0;
    #1;
    chk("t5_rst_abort", 128'({grant, busy, m0_Rvalid, m1_Rvalid}), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rstn = 1; m0_Rready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t5_no_rvalid", 128'({m0_Rvalid, busy, grant}), 128'(0));
    end

    chk("exp_grant_left", 128'(exp_g.size()), 128'(0));
    chk("exp_rsp_left", 128'(exp_r.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
